// File: rtl/grid_scorekeeper.sv
// Playfield scorekeeper: counts grid cells, detects locks/clears by frame delta, tracks score/lines/level/game-over.
// Latency: grid change -> counts +1 frame -> lock_pulse/score/lines +2 frames. No backpressure; consumes every frame.
module grid_scorekeeper #(
    parameter int COLS            = 10,
    parameter int ROWS            = 22,
    parameter int SPAWN_ROWS      = 2,
    parameter int LINES_PER_LEVEL = 10,
    parameter int MAX_LEVEL       = 15,
    parameter int BASE_DROP       = 20,
    parameter int MIN_DROP        = 2
) (
    input  logic                             frame_clk,
    input  logic                             Reset,
    input  logic [COLS-1:0][ROWS-1:0][3:0]   grid,
    output logic [19:0]                      score,
    output logic [9:0]                       lines,
    output logic [3:0]                       level,
    output logic [7:0]                       drop_period,
    output logic                             lock_pulse,
    output logic [2:0]                       clear_count,
    output logic                             err_pulse,
    output logic                             game_over
);

    typedef enum logic [1:0] {EMPTY, PLAYING, OVER} state_t;

    state_t       state_q, state_d;
    logic [7:0]   act_nxt, set_nxt, act_cnt, set_cnt, act_prev, set_prev;
    logic         top_nxt, top_occ, cnt_valid, prev_valid;
    logic [3:0]   lines_in_level, lil_nxt, level_nxt;
    logic         lock_det, k_ok, credit;
    logic [2:0]   k_val;
    logic signed [8:0] delta;
    logic [10:0]  base_pts;
    logic [4:0]   lvl_p1, lil_sum;
    logic [15:0]  add_pts;
    logic [20:0]  score_sum;
    logic [10:0]  lines_sum;
    logic signed [9:0] drop_raw;
    logic [7:0]   drop_nxt;

    // Stage 1: reduce the grid to cell counts and spawn-zone occupancy
    always_comb begin
        act_nxt = '0;
        set_nxt = '0;
        top_nxt = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                if (grid[c][r] == 4'd1) begin
                    act_nxt = act_nxt + 8'd1;
                end else if (grid[c][r] >= 4'd2) begin
                    set_nxt = set_nxt + 8'd1;
                    if (r < SPAWN_ROWS) top_nxt = 1'b1;
                end
            end
        end
    end

    // prev_valid only rises once act_prev/set_prev hold a real post-reset sample
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            act_cnt    <= '0;
            set_cnt    <= '0;
            top_occ    <= 1'b0;
            act_prev   <= '0;
            set_prev   <= '0;
            cnt_valid  <= 1'b0;
            prev_valid <= 1'b0;
        end else begin
            act_cnt    <= act_nxt;
            set_cnt    <= set_nxt;
            top_occ    <= top_nxt;
            act_prev   <= act_cnt;
            set_prev   <= set_cnt;
            cnt_valid  <= 1'b1;
            prev_valid <= cnt_valid;
        end
    end

    // Stage 2: lock detection and line-clear decode
    always_comb begin
        lock_det = prev_valid && (set_cnt != set_prev) && (state_q == PLAYING);
        delta    = $signed({1'b0, set_prev} + {1'b0, act_prev} - {1'b0, set_cnt});
        k_val    = 3'd0;
        k_ok     = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            if (delta == 9'(k * COLS)) begin
                k_val = 3'(k);
                k_ok  = 1'b1;
            end
        end
        credit = lock_det && k_ok;
    end

    // Scoring uses the level in force before this lock's increment
    always_comb begin
        case (k_val)
            3'd1:    base_pts = 11'd40;
            3'd2:    base_pts = 11'd100;
            3'd3:    base_pts = 11'd300;
            3'd4:    base_pts = 11'd1200;
            default: base_pts = 11'd0;
        endcase
        lvl_p1    = {1'b0, level} + 5'd1;
        add_pts   = 16'(base_pts) * 16'(lvl_p1);
        score_sum = {1'b0, score} + {5'd0, add_pts};
        lines_sum = {1'b0, lines} + 11'(k_val);
        lil_sum   = {1'b0, lines_in_level} + 5'(k_val);
        lil_nxt   = lil_sum[3:0];
        level_nxt = level;
        if (lil_sum >= 5'(LINES_PER_LEVEL)) begin
            lil_nxt = 4'(lil_sum - 5'(LINES_PER_LEVEL));
            if (level < 4'(MAX_LEVEL)) level_nxt = level + 4'd1;
        end
        drop_raw = 10'(BASE_DROP) - $signed({6'd0, level_nxt});
        drop_nxt = (drop_raw > 10'(MIN_DROP)) ? 8'(drop_raw) : 8'(MIN_DROP);
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            score          <= '0;
            lines          <= '0;
            level          <= '0;
            lines_in_level <= '0;
            drop_period    <= 8'(BASE_DROP);
            lock_pulse     <= 1'b0;
            err_pulse      <= 1'b0;
            clear_count    <= '0;
        end else begin
            lock_pulse <= lock_det;
            err_pulse  <= lock_det && !k_ok;
            if (lock_det) clear_count <= k_ok ? k_val : 3'd0;
            if (credit) begin
                score          <= (score_sum > 21'd999999) ? 20'd999999 : score_sum[19:0];
                lines          <= (lines_sum > 11'd999) ? 10'd999 : lines_sum[9:0];
                lines_in_level <= lil_nxt;
                level          <= level_nxt;
                drop_period    <= drop_nxt;
            end
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (act_cnt != 8'd0) state_d = PLAYING;
            PLAYING: if (lock_det && top_occ) state_d = OVER;
            default: state_d = OVER;
        endcase
    end

    always_comb begin
        game_over = (state_q == OVER);
    end

endmodule

// File: tb/tb_grid_scorekeeper.sv
// Scoreboard bench for grid_scorekeeper: a count-level model predicts each frame's outputs two frames ahead.
module tb_grid_scorekeeper;
    localparam int COLS = 10;
    localparam int ROWS = 22;

    typedef logic [COLS-1:0][ROWS-1:0][3:0] grid_t;

    typedef struct {
        logic        lock;
        logic        err;
        logic [2:0]  cc;
        logic [19:0] score;
        logic [9:0]  lines;
        logic [3:0]  level;
        logic [7:0]  drop;
        logic        go;
        int          frame;
    } exp_t;

    logic        frame_clk = 1'b0;
    logic        Reset;
    grid_t       grid;
    logic [19:0] score;
    logic [9:0]  lines;
    logic [3:0]  level;
    logic [7:0]  drop_period;
    logic        lock_pulse;
    logic [2:0]  clear_count;
    logic        err_pulse;
    logic        game_over;

    exp_t sbq[$];
    int checks   = 0;
    int failures = 0;

    int m_score, m_lines, m_level, m_lil, m_state, m_cc, m_frames, m_act_prev, m_set_prev;

    grid_scorekeeper dut (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .grid        (grid),
        .score       (score),
        .lines       (lines),
        .level       (level),
        .drop_period (drop_period),
        .lock_pulse  (lock_pulse),
        .clear_count (clear_count),
        .err_pulse   (err_pulse),
        .game_over   (game_over)
    );

    always #5 frame_clk = ~frame_clk;

    // Settled cells fill from the bottom row upward, active cells stack above them
    function automatic grid_t mk(input int a, input int s, input bit top);
        grid_t g;
        int s_rem;
        g = '0;
        s_rem = s;
        if (top) begin
            g[0][1] = 4'd2;
            s_rem = s - 1;
        end
        for (int i = 0; i < s_rem; i++) g[i % COLS][ROWS - 1 - i / COLS] = 4'd2;
        for (int j = 0; j < a; j++) g[(s_rem + j) % COLS][ROWS - 1 - (s_rem + j) / COLS] = 4'd1;
        return g;
    endfunction

    task automatic model_reset();
        m_score = 0; m_lines = 0; m_level = 0; m_lil = 0;
        m_state = 0; m_cc = 0; m_frames = 0; m_act_prev = 0; m_set_prev = 0;
        sbq.delete();
    endtask

    task automatic do_reset(input grid_t g);
        @(negedge frame_clk);
        Reset = 1'b1;
        grid  = g;
        repeat (3) @(posedge frame_clk);
        model_reset();
    endtask

    // Drive one frame, predict its outputs, and retire the prediction made two frames earlier
    task automatic apply_frame(input grid_t g);
        exp_t e, n;
        int a, s, d, k;
        bit top, lock;
        @(negedge frame_clk);
        if (sbq.size() == 2) begin
            e = sbq.pop_front();
            checks += 8;
            if (lock_pulse !== e.lock) begin failures++; $display("FAIL lock_pulse frame %0d: got %0d expected %0d", e.frame, lock_pulse, e.lock); end
            if (err_pulse !== e.err) begin failures++; $display("FAIL err_pulse frame %0d: got %0d expected %0d", e.frame, err_pulse, e.err); end
            if (clear_count !== e.cc) begin failures++; $display("FAIL clear_count frame %0d: got %0d expected %0d", e.frame, clear_count, e.cc); end
            if (score !== e.score) begin failures++; $display("FAIL score frame %0d: got %0d expected %0d", e.frame, score, e.score); end
            if (lines !== e.lines) begin failures++; $display("FAIL lines frame %0d: got %0d expected %0d", e.frame, lines, e.lines); end
            if (level !== e.level) begin failures++; $display("FAIL level frame %0d: got %0d expected %0d", e.frame, level, e.level); end
            if (drop_period !== e.drop) begin failures++; $display("FAIL drop_period frame %0d: got %0d expected %0d", e.frame, drop_period, e.drop); end
            if (game_over !== e.go) begin failures++; $display("FAIL game_over frame %0d: got %0d expected %0d", e.frame, game_over, e.go); end
        end
        Reset = 1'b0;
        grid  = g;
        a = 0; s = 0; top = 1'b0;
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++) begin
                if (g[c][r] == 4'd1) a++;
                else if (g[c][r] >= 4'd2) begin s++; if (r < 2) top = 1'b1; end
            end
        lock = (m_state == 1) && (m_frames >= 1) && (s != m_set_prev);
        n.err = 1'b0;
        if (lock) begin
            d = m_set_prev + m_act_prev - s;
            if (d >= 0 && d <= 40 && d % 10 == 0) begin
                k = d / 10;
                m_cc = k;
                case (k)
                    1: m_score += 40 * (m_level + 1);
                    2: m_score += 100 * (m_level + 1);
                    3: m_score += 300 * (m_level + 1);
                    4: m_score += 1200 * (m_level + 1);
                    default: ;
                endcase
                if (m_score > 999999) m_score = 999999;
                m_lines += k;
                if (m_lines > 999) m_lines = 999;
                m_lil += k;
                if (m_lil >= 10) begin
                    m_lil -= 10;
                    if (m_level < 15) m_level++;
                end
            end else begin
                m_cc = 0;
                n.err = 1'b1;
            end
        end
        if (m_state == 0 && a != 0) m_state = 1;
        else if (m_state == 1 && lock && top) m_state = 2;
        m_act_prev = a;
        m_set_prev = s;
        n.lock  = lock;
        n.cc    = 3'(m_cc);
        n.score = 20'(m_score);
        n.lines = 10'(m_lines);
        n.level = 4'(m_level);
        n.drop  = 8'((20 - m_level > 2) ? 20 - m_level : 2);
        n.go    = (m_state == 2);
        n.frame = m_frames;
        sbq.push_back(n);
        m_frames++;
    endtask

    task automatic test_reset();
        do_reset('0);
        @(negedge frame_clk);
        checks += 8;
        if (score !== 20'd0) begin failures++; $display("FAIL reset_score: got %0d expected 0", score); end
        if (lines !== 10'd0) begin failures++; $display("FAIL reset_lines: got %0d expected 0", lines); end
        if (level !== 4'd0) begin failures++; $display("FAIL reset_level: got %0d expected 0", level); end
        if (drop_period !== 8'd20) begin failures++; $display("FAIL reset_drop: got %0d expected 20", drop_period); end
        if (game_over !== 1'b0) begin failures++; $display("FAIL reset_game_over: got %0d expected 0", game_over); end
        if (lock_pulse !== 1'b0) begin failures++; $display("FAIL reset_lock: got %0d expected 0", lock_pulse); end
        if (err_pulse !== 1'b0) begin failures++; $display("FAIL reset_err: got %0d expected 0", err_pulse); end
        if (clear_count !== 3'd0) begin failures++; $display("FAIL reset_cc: got %0d expected 0", clear_count); end
        repeat (4) apply_frame('0);
    endtask

    task automatic test_lock_no_clear();
        grid_t g1, g2, g3;
        g1 = '0; g2 = '0; g3 = '0;
        for (int c = 4; c < 6; c++) begin
            g1[c][0] = 4'd1;  g1[c][1] = 4'd1;
            g2[c][10] = 4'd1; g2[c][11] = 4'd1;
            g3[c][20] = 4'd2; g3[c][21] = 4'd2;
        end
        do_reset('0);
        apply_frame(g1);
        apply_frame(g2);
        apply_frame(g3);
        repeat (3) apply_frame(g3);
    endtask

    task automatic test_single_clear();
        grid_t base, g1, g2, g3;
        base = '0;
        for (int c = 0; c < COLS; c++) if (c < 4 || c > 5) base[c][21] = 4'd2;
        g1 = base; g2 = base; g3 = '0;
        for (int c = 4; c < 6; c++) begin
            g1[c][18] = 4'd1; g1[c][19] = 4'd1;
            g2[c][20] = 4'd1; g2[c][21] = 4'd1;
            g3[c][21] = 4'd2;
        end
        do_reset('0);
        apply_frame(g1);
        apply_frame(g2);
        apply_frame(g3);
        repeat (3) apply_frame(g3);
        checks++;
        if (score !== 20'd40) begin failures++; $display("FAIL single_clear_score: got %0d expected 40", score); end
    endtask

    task automatic test_level_up();
        do_reset('0);
        for (int i = 0; i < 10; i++) begin
            apply_frame(mk(11, i, 1'b0));
            apply_frame(mk(0, i + 1, 1'b0));
        end
        apply_frame(mk(21, 10, 1'b0));
        apply_frame(mk(0, 11, 1'b0));
        repeat (3) apply_frame(mk(0, 11, 1'b0));
        checks += 3;
        if (level !== 4'd1) begin failures++; $display("FAIL level_up_level: got %0d expected 1", level); end
        if (drop_period !== 8'd19) begin failures++; $display("FAIL level_up_drop: got %0d expected 19", drop_period); end
        if (score !== 20'd600) begin failures++; $display("FAIL level_up_score: got %0d expected 600", score); end
    endtask

    task automatic test_game_over();
        do_reset('0);
        apply_frame(mk(11, 5, 1'b0));
        apply_frame(mk(0, 6, 1'b1));
        apply_frame(mk(4, 6, 1'b1));
        apply_frame(mk(0, 10, 1'b1));
        apply_frame(mk(11, 10, 1'b1));
        apply_frame(mk(0, 11, 1'b1));
        repeat (3) apply_frame(mk(0, 11, 1'b1));
        checks += 2;
        if (game_over !== 1'b1) begin failures++; $display("FAIL game_over_sticky: got %0d expected 1", game_over); end
        if (score !== 20'd40) begin failures++; $display("FAIL game_over_frozen: got %0d expected 40", score); end
    endtask

    task automatic test_reset_over();
        grid_t full;
        for (int c = 0; c < COLS; c++) for (int r = 0; r < ROWS; r++) full[c][r] = 4'd2;
        do_reset(full);
        @(negedge frame_clk);
        checks += 5;
        if (score !== 20'd0) begin failures++; $display("FAIL over_reset_score: got %0d expected 0", score); end
        if (lines !== 10'd0) begin failures++; $display("FAIL over_reset_lines: got %0d expected 0", lines); end
        if (game_over !== 1'b0) begin failures++; $display("FAIL over_reset_game_over: got %0d expected 0", game_over); end
        if (drop_period !== 8'd20) begin failures++; $display("FAIL over_reset_drop: got %0d expected 20", drop_period); end
        if (lock_pulse !== 1'b0) begin failures++; $display("FAIL over_reset_lock: got %0d expected 0", lock_pulse); end
        repeat (3) apply_frame(full);
        apply_frame(mk(4, 0, 1'b0));
        apply_frame(mk(0, 3, 1'b0));
        repeat (3) apply_frame(mk(0, 3, 1'b0));
        checks++;
        if (score !== 20'd0) begin failures++; $display("FAIL err_score_unchanged: got %0d expected 0", score); end
    endtask

    initial begin
        Reset = 1'b1;
        grid  = '0;
        model_reset();
        test_reset();
        test_lock_no_clear();
        test_single_clear();
        test_level_up();
        test_game_over();
        test_reset_over();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
